// File: rtl/cpu_pkg.sv
// Shared CPU constants for the branch-immediate path.
// Latency: none (constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int IMM_W  = 16;

  // A branch offset is measured from the instruction after the branch.
  localparam int PC_INC = 4;

  // Bit positions inside the packed error vector.
  localparam int ERR_ALIGN = 0;
  localparam int ERR_RANGE = 1;

endpackage

// File: rtl/branch_off_check.sv
// Splits a byte offset into the branch immediate and its alignment/range status.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module branch_off_check #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [ADDR_W-1:0] diff,
  output logic [IMM_W-1:0]  imm,
  output logic              err_align,
  output logic              err_range
);

  // Bits above the signed reach must all equal the sign bit of the reach.
  logic [ADDR_W-IMM_W-2:0] upper;

  assign upper = diff[ADDR_W-1:IMM_W+1];

  // Immediate is the word offset; flags report what truncation would lose.
  always_comb begin
    imm       = diff[IMM_W+1:2];
    err_align = |diff[1:0];
    err_range = (|upper) && !(&upper);
  end

endmodule

// File: rtl/branch_imm_encoder.sv
// Converts an absolute branch target into the MIPS 16-bit branch immediate.
// Latency: 2 cycles from input accept to out_valid, 1 result per cycle.
// Backpressure: in_ready follows out_ready combinationally; no skid buffer.
module branch_imm_encoder #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int IMM_W  = cpu_pkg::IMM_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_err_align,
  output logic              out_err_range,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  import cpu_pkg::*;

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_diff;
  logic              s2_valid;
  logic [IMM_W-1:0]  s2_imm;
  logic [1:0]        s2_err;

  logic              s1_adv;
  logic              s2_adv;
  logic [IMM_W-1:0]  chk_imm;
  logic              chk_align;
  logic              chk_range;
  logic              out_fire;

  // A stage may load when it is empty or its contents leave this cycle.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    out_fire = s2_valid && out_ready;
    busy     = s1_valid || s2_valid;
  end

  // Stage 1: byte offset relative to the delay-slot address, wrapping modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff <= in_target - in_pc - ADDR_W'(PC_INC);
      end
    end
  end

  branch_off_check #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_check (
    .diff      (s1_diff),
    .imm       (chk_imm),
    .err_align (chk_align),
    .err_range (chk_range)
  );

  // Stage 2: registered immediate and flags; data only moves when S1 holds an entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_err   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_imm            <= chk_imm;
        s2_err[ERR_ALIGN] <= chk_align;
        s2_err[ERR_RANGE] <= chk_range;
      end
    end
  end

  // Count delivered results carrying any error; sticks at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (out_fire && (|s2_err) && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

  assign out_valid     = s2_valid;
  assign out_imm       = s2_imm;
  assign out_err_align = s2_err[ERR_ALIGN];
  assign out_err_range = s2_err[ERR_RANGE];

endmodule

// File: tb/tb_branch_imm_encoder.sv
// Directed bench for branch_imm_encoder: encoding, range/alignment edges,
// backpressure ordering and asynchronous reset.
// Inputs change on the falling edge; outputs are sampled #1 after rising edges or at falling edges.
module tb_branch_imm_encoder;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic        out_err_align;
  logic        out_err_range;
  logic [15:0] err_count;
  logic        busy;

  int errors = 0;
  int checks = 0;

  branch_imm_encoder dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pc         (in_pc),
    .in_target     (in_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_imm       (out_imm),
    .out_err_align (out_err_align),
    .out_err_range (out_err_range),
    .err_count     (err_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one request with out_ready high and returns the result and the number of
  // extra rising edges after the accept edge until out_valid appeared (10 = timeout).
  task automatic run_req(input logic [31:0] pc, input logic [31:0] tgt,
                         output logic [15:0] imm, output logic al, output logic rg,
                         output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_target = tgt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    imm = out_imm;
    al  = out_err_align;
    rg  = out_err_range;
    // Let the output transfer edge happen.
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_target = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_err_align, out_err_range, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {out_valid, out_err_align, out_err_range, busy});
    end
    checks++;
    if (out_imm !== 16'h0000 || err_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: imm=%h cnt=%0d want 0/0", out_imm, err_count);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_forward();
    logic [15:0] imm;
    logic al, rg;
    int lat;
    run_req(32'h0040_0000, 32'h0040_0010, imm, al, rg, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL fwd_latency: extra edges %0d want 1", lat);
    end
    checks++;
    if ({imm, al, rg} !== {16'h0003, 2'b00}) begin
      errors++;
      $display("FAIL fwd_result: imm=%h al=%b rg=%b want 0003 0 0", imm, al, rg);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL fwd_err_count: got %0d want 0", err_count);
    end
  endtask

  task automatic test_backward();
    logic [15:0] imm;
    logic al, rg;
    int lat;
    run_req(32'h0040_0010, 32'h0040_0000, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'hFFFB, 2'b00} || lat !== 1) begin
      errors++;
      $display("FAIL bwd_result: imm=%h al=%b rg=%b lat=%0d want FFFB 0 0 1", imm, al, rg, lat);
    end
  endtask

  task automatic test_range_edges();
    logic [15:0] imm;
    logic al, rg;
    int lat;
    run_req(32'h0000_1000, 32'h0002_1000, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h7FFF, 2'b00}) begin
      errors++;
      $display("FAIL range_max: imm=%h al=%b rg=%b want 7FFF 0 0", imm, al, rg);
    end
    run_req(32'h0000_1000, 32'hFFFE_1004, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h8000, 2'b00}) begin
      errors++;
      $display("FAIL range_min: imm=%h al=%b rg=%b want 8000 0 0", imm, al, rg);
    end
    run_req(32'h0000_1000, 32'h0002_1004, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h8000, 2'b01}) begin
      errors++;
      $display("FAIL range_over: imm=%h al=%b rg=%b want 8000 0 1", imm, al, rg);
    end
    checks++;
    if (err_count !== 16'd1) begin
      errors++;
      $display("FAIL range_err_count: got %0d want 1", err_count);
    end
  endtask

  task automatic test_align_wrap();
    logic [15:0] imm;
    logic al, rg;
    int lat;
    run_req(32'h0040_0000, 32'h0040_0012, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h0003, 2'b10}) begin
      errors++;
      $display("FAIL align_err: imm=%h al=%b rg=%b want 0003 1 0", imm, al, rg);
    end
    run_req(32'hFFFF_FFFC, 32'h0000_0000, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL wrap_zero: imm=%h al=%b rg=%b want 0000 0 0", imm, al, rg);
    end
    // diff = 0x40002: misaligned and out of reach at once.
    run_req(32'h0000_0000, 32'h0004_0006, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL both_flags: imm=%h al=%b rg=%b want 0000 1 1", imm, al, rg);
    end
    checks++;
    if (err_count !== 16'd3) begin
      errors++;
      $display("FAIL align_err_count: got %0d want 3", err_count);
    end
  endtask

  // Four requests with imm 1..4; out_ready held low for the first 6 cycles.
  task automatic test_back_to_back();
    int idx = 0;
    int nout = 0;
    int first_out_cyc = -1;
    logic acc;
    logic [15:0] held = '0;
    logic have_held = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      if (idx < 4) begin
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0100;
        in_target = 32'h0000_0104 + 32'(4 * (idx + 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 5) begin
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: accepts=%0d in_ready=%b want 2 0", idx, in_ready);
        end
      end
      if (cyc < 6 && out_valid) begin
        if (!have_held) begin
          held = out_imm;
          have_held = 1'b1;
        end else begin
          checks++;
          if (out_imm !== held) begin
            errors++;
            $display("FAIL bp_stable: cycle %0d imm=%h want %h", cyc, out_imm, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (first_out_cyc < 0) first_out_cyc = cyc;
        checks++;
        if (out_imm !== 16'(nout + 1) || cyc !== first_out_cyc + nout) begin
          errors++;
          $display("FAIL bp_order: cycle %0d imm=%h want %h at cycle %0d",
                   cyc, out_imm, 16'(nout + 1), first_out_cyc + nout);
        end
        nout++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    checks++;
    if (nout !== 4 || first_out_cyc !== 6) begin
      errors++;
      $display("FAIL bp_count: outputs=%0d first=%0d want 4 at 6", nout, first_out_cyc);
    end
    checks++;
    if (err_count !== 16'd3) begin
      errors++;
      $display("FAIL bp_err_count: got %0d want 3", err_count);
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] imm;
    logic al, rg;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h0000_0000;
    in_target = 32'h0000_0008;
    @(posedge clk);
    @(negedge clk);
    in_target = 32'h0000_000C;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b11 || err_count !== 16'd3) begin
      errors++;
      $display("FAIL mid_preload: valid=%b busy=%b cnt=%0d want 1 1 3", out_valid, busy, err_count);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy} !== 2'b00 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_async_reset: valid=%b busy=%b cnt=%0d want 0 0 0", out_valid, busy, err_count);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    run_req(32'h0040_0000, 32'h0040_0010, imm, al, rg, lat);
    checks++;
    if ({imm, al, rg} !== {16'h0003, 2'b00} || lat !== 1) begin
      errors++;
      $display("FAIL mid_after: imm=%h al=%b rg=%b lat=%0d want 0003 0 0 1", imm, al, rg, lat);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backward();
    test_range_edges();
    test_align_wrap();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
